// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the FSM state type for the instruction-memory slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  function automatic logic is_active_trans(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-wide storage with one synchronous write-first read port and one write port.
// The read register reads zero whenever no read is issued, so it can drive HRDATA directly.
module imem_array #(
  parameter int  WORDS = 4096,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [31:0]   i_wr_data
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rd_data;

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register with same-cycle write forwarding.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data <= 32'h0000_0000;
    end else if (i_rd_en) begin
      r_rd_data <= (i_wr_en && (i_wr_addr == i_rd_addr)) ? i_wr_data : r_mem[i_rd_addr];
    end else begin
      r_rd_data <= 32'h0000_0000;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ahb_imem_slave.sv
// AHB-Lite instruction-memory slave with programmable read wait states and backdoor preload.
// Optional feature macro IMEM_WRITE_EN enables AHB word writes; otherwise every write errors.
module ahb_imem_slave
  import ahb_pkg::*;
#(
  parameter int  MEM_WORDS   = 4096,
  parameter int  WAIT_STATES = 2,
  localparam int AW          = $clog2(MEM_WORDS)
) (
  input  logic          hclk,
  input  logic          hrst,
  input  logic          hsel,
  input  logic [31:0]   haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [31:0]   hwdata,
  input  logic          hreadyin,
  output logic [31:0]   hrdata,
  output logic          hreadyout,
  output logic          hresp,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  state_e        r_state;
  state_e        w_next;
  logic [AW-1:0] r_idx;
  logic          r_write;
  logic [3:0]    r_cnt;
  logic          r_hreadyout;
  logic          r_hresp;

  logic          w_can_accept;
  logic          w_accept;
  logic          w_err;
  logic          w_bad_write;
  logic [AW-1:0] w_haddr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_rd_write;
  logic          w_rd_en;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [31:0]   w_wr_data;
  logic [31:0]   w_rdata;

  // Only states that present hreadyout = 1 can overlap a new address phase.
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
  assign w_accept     = w_can_accept & hsel & hreadyin & is_active_trans(htrans);
  assign w_haddr_idx  = haddr[AW+1:2];
  assign w_err        = (hsize != HSIZE_WORD) | (haddr[1:0] != 2'b00) |
                        ({2'b00, haddr[31:2]} >= 32'(MEM_WORDS)) | w_bad_write;

`ifdef IMEM_WRITE_EN
  // The single write port goes to the preload whenever it strobes.
  assign w_bad_write = 1'b0;
  assign w_wr_en     = ld_en | ((r_state == ST_DATA) & r_write);
  assign w_wr_addr   = ld_en ? ld_addr : r_idx;
  assign w_wr_data   = ld_en ? ld_data : hwdata;
`else
  logic w_unused_hwdata;
  assign w_unused_hwdata = ^hwdata;
  assign w_bad_write     = hwrite;
  assign w_wr_en         = ld_en;
  assign w_wr_addr       = ld_addr;
  assign w_wr_data       = ld_data;
`endif

  // Read is issued the cycle before DATA, from the live bus when WAIT is skipped.
  assign w_rd_idx   = w_accept ? w_haddr_idx : r_idx;
  assign w_rd_write = w_accept ? hwrite : r_write;
  assign w_rd_en    = (w_next == ST_DATA) & ~w_rd_write;

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (w_accept) begin
          if (w_err) begin
            w_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_next = ST_WAIT;
          end else begin
            w_next = ST_DATA;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = ST_DATA;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_ERR1: w_next = ST_ERR2;
      default: w_next = ST_IDLE;
    endcase
  end

  // Control state, wait counter and registered handshake outputs.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      r_state     <= ST_IDLE;
      r_idx       <= {AW{1'b0}};
      r_write     <= 1'b0;
      r_cnt       <= 4'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx   <= w_haddr_idx;
        r_write <= hwrite;
      end
      if ((w_next == ST_WAIT) && (r_state != ST_WAIT)) begin
        r_cnt <= 4'(WAIT_STATES - 1);
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_cnt <= 4'd0;
      end
      r_hreadyout <= (w_next != ST_WAIT) && (w_next != ST_ERR1);
      r_hresp     <= ((w_next == ST_ERR1) || (w_next == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end
  end

  imem_array #(.WORDS(MEM_WORDS)) u_array (
    .i_clk     (hclk),
    .i_rst     (hrst),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_idx),
    .o_rd_data (w_rdata),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data)
  );

  assign hrdata    = w_rdata;
  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;

endmodule
